// File: rtl/adder_seq_ctrl.sv
// adder_seq_ctrl: sequential W-bit adder that ripples one 4-bit nibble per
// clock through a chain of four full_adder cells, under an IDLE/ADD/DONE FSM.
// Ports: clk, rst (async, active-high), start, x, y (operands, W=4*NIBBLES),
//        busy (high in ADD), done (1-cycle pulse), sum, carry (registered).
// Optional: define ADDER_SEQ_SUB_EN to add a 'sub' input (A-B, carry=1 means
//           no borrow). Without it every operation is an add with carry-in 0.

module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);
    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

module adder_seq_ctrl #(
    parameter int NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [4*NIBBLES-1:0]   x,
    input  logic [4*NIBBLES-1:0]   y,
`ifdef ADDER_SEQ_SUB_EN
    input  logic                   sub,
`endif
    output logic                   busy,
    output logic                   done,
    output logic [4*NIBBLES-1:0]   sum,
    output logic                   carry
);
    localparam int W  = 4 * NIBBLES;
    localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ADD  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]    state;
    logic [IW-1:0] idx;
    logic [W-1:0]  a_reg;
    logic [W-1:0]  b_reg;
    logic          carry_reg;
    logic          carry_init;
    logic          last;

    logic [3:0]    a_nib;
    logic [3:0]    b_nib;
    logic [3:0]    s_nib;
    logic [4:0]    c;
    logic [W-1:0]  sum_next;

`ifdef ADDER_SEQ_SUB_EN
    logic sub_reg;
    // Subtraction is A + ~B + 1: invert B per nibble, seed carry with 1.
    assign carry_init = sub;
`else
    assign carry_init = 1'b0;
`endif

    // Select the active operand nibbles and merge the result nibble back.
    always_comb begin
        a_nib    = 4'h0;
        b_nib    = 4'h0;
        sum_next = sum;
        for (int k = 0; k < NIBBLES; k++) begin
            if (idx == IW'(k)) begin
                a_nib = a_reg[4*k +: 4];
                b_nib = b_reg[4*k +: 4];
                sum_next[4*k +: 4] = s_nib;
            end
        end
`ifdef ADDER_SEQ_SUB_EN
        b_nib = b_nib ^ {4{sub_reg}};
`endif
    end

    assign c[0] = carry_reg;

    for (genvar i = 0; i < 4; i++) begin : g_fa
        full_adder u_fa (
            .a    (a_nib[i]),
            .b    (b_nib[i]),
            .cin  (c[i]),
            .s    (s_nib[i]),
            .cout (c[i+1])
        );
    end

    assign last = (idx == IW'(NIBBLES - 1));
    assign busy = (state == ADD);
    assign done = (state == DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            idx       <= '0;
            a_reg     <= '0;
            b_reg     <= '0;
            carry_reg <= 1'b0;
            sum       <= '0;
            carry     <= 1'b0;
`ifdef ADDER_SEQ_SUB_EN
            sub_reg   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_reg     <= x;
                        b_reg     <= y;
                        idx       <= '0;
                        carry_reg <= carry_init;
                        sum       <= '0;
                        carry     <= 1'b0;
`ifdef ADDER_SEQ_SUB_EN
                        sub_reg   <= sub;
`endif
                        state     <= ADD;
                    end
                end
                ADD: begin
                    sum       <= sum_next;
                    carry_reg <= c[4];
                    if (last) begin
                        carry <= c[4];
                        idx   <= '0;
                        state <= DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_adder_seq_ctrl.sv
// tb_adder_seq_ctrl: directed bench for adder_seq_ctrl (NIBBLES=4 and 1).
// Hand-computed vectors; one task per scenario with inline comparisons.

module tb_adder_seq_ctrl;
    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] x;
    logic [15:0] y;
    logic        sub;
    logic        busy;
    logic        done;
    logic [15:0] sum;
    logic        carry;

    logic        start1;
    logic [3:0]  x1;
    logic [3:0]  y1;
    logic        busy1;
    logic        done1;
    logic [3:0]  sum1;
    logic        carry1;

    int errs;
    int checks;

    adder_seq_ctrl #(.NIBBLES(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .x     (x),
        .y     (y),
`ifdef ADDER_SEQ_SUB_EN
        .sub   (sub),
`endif
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .carry (carry)
    );

    adder_seq_ctrl #(.NIBBLES(1)) dut1 (
        .clk   (clk),
        .rst   (rst),
        .start (start1),
        .x     (x1),
        .y     (y1),
`ifdef ADDER_SEQ_SUB_EN
        .sub   (1'b0),
`endif
        .busy  (busy1),
        .done  (done1),
        .sum   (sum1),
        .carry (carry1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse start, scramble operands after accept, wait for done (bounded).
    task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                          input logic s, output int lat, output int nb);
        x = a;
        y = b;
        sub = s;
        start = 1'b1;
        tick();
        start = 1'b0;
        x = ~a;
        y = ~b;
        sub = ~s;
        lat = 0;
        nb = 0;
        while (!done && lat < 20) begin
            if (busy) nb++;
            tick();
            lat++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({busy, done, carry, sum} !== 19'h0) begin
            errs++;
            $display("FAIL reset_state: got busy=%b done=%b carry=%b sum=%h want 0",
                     busy, done, carry, sum);
        end
        checks++;
        if ({busy1, done1, carry1, sum1} !== 7'h0) begin
            errs++;
            $display("FAIL reset_state_n1: got busy=%b done=%b carry=%b sum=%h want 0",
                     busy1, done1, carry1, sum1);
        end
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        int lat, nb;
        run_op(16'h1234, 16'h4321, 1'b0, lat, nb);
        checks++;
        if (lat !== 4) begin
            errs++;
            $display("FAIL basic_latency: got %0d want 4", lat);
        end
        checks++;
        if (nb !== 4) begin
            errs++;
            $display("FAIL basic_busy_cycles: got %0d want 4", nb);
        end
        checks++;
        if (sum !== 16'h5555 || carry !== 1'b0) begin
            errs++;
            $display("FAIL basic_result: got sum=%h carry=%b want 5555 0", sum, carry);
        end
        tick();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || sum !== 16'h5555) begin
            errs++;
            $display("FAIL basic_hold: got done=%b busy=%b sum=%h want 0 0 5555",
                     done, busy, sum);
        end
        tick();
    endtask

    task automatic test_carry_ripple();
        int lat, nb;
        run_op(16'hFFFF, 16'h0001, 1'b0, lat, nb);
        checks++;
        if (lat !== 4 || sum !== 16'h0000 || carry !== 1'b1) begin
            errs++;
            $display("FAIL carry_ripple: got lat=%0d sum=%h carry=%b want 4 0000 1",
                     lat, sum, carry);
        end
        tick();
        checks++;
        if (carry !== 1'b1 || done !== 1'b0) begin
            errs++;
            $display("FAIL carry_hold: got carry=%b done=%b want 1 0", carry, done);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [15:0] xs [18];
        logic [15:0] ys [18];
        logic [16:0] exp;
        for (int i = 0; i < 18; i++) begin
            xs[i] = 16'(i * 16'h0911 + 16'h0123);
            ys[i] = 16'(i * 16'h1357) ^ 16'h8000;
        end
        start = 1'b1;
        for (int i = 0; i < 18; i++) begin
            x = xs[i];
            y = ys[i];
            tick();
            if (i % 6 == 4) begin
                exp = {1'b0, xs[i-4]} + {1'b0, ys[i-4]};
                checks++;
                if (done !== 1'b1 || {carry, sum} !== exp) begin
                    errs++;
                    $display("FAIL b2b_op%0d: got done=%b carry=%b sum=%h want 1 %b %h",
                             i / 6, done, carry, sum, exp[16], exp[15:0]);
                end
            end else if (done !== 1'b0) begin
                checks++;
                errs++;
                $display("FAIL b2b_spurious_done: cycle %0d got done=1 want 0", i);
            end
        end
        start = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_reset_abort();
        int lat, nb;
        int seen;
        x = 16'hAAAA;
        y = 16'h5555;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        #1;
        checks++;
        if ({busy, done, carry, sum} !== 19'h0) begin
            errs++;
            $display("FAIL abort_clear: got busy=%b done=%b carry=%b sum=%h want 0",
                     busy, done, carry, sum);
        end
        tick();
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            if (done) seen++;
            tick();
        end
        checks++;
        if (seen !== 0) begin
            errs++;
            $display("FAIL abort_no_done: got %0d pulses want 0", seen);
        end
        run_op(16'h0F0F, 16'h0101, 1'b0, lat, nb);
        checks++;
        if (lat !== 4 || sum !== 16'h1010 || carry !== 1'b0) begin
            errs++;
            $display("FAIL abort_next_op: got lat=%0d sum=%h carry=%b want 4 1010 0",
                     lat, sum, carry);
        end
        tick();
    endtask

`ifdef ADDER_SEQ_SUB_EN
    task automatic test_subtract();
        int lat, nb;
        run_op(16'h0005, 16'h0007, 1'b1, lat, nb);
        checks++;
        if (lat !== 4 || sum !== 16'hFFFE || carry !== 1'b0) begin
            errs++;
            $display("FAIL sub_borrow: got lat=%0d sum=%h carry=%b want 4 fffe 0",
                     lat, sum, carry);
        end
        tick();
        run_op(16'h0007, 16'h0005, 1'b1, lat, nb);
        checks++;
        if (lat !== 4 || sum !== 16'h0002 || carry !== 1'b1) begin
            errs++;
            $display("FAIL sub_noborrow: got lat=%0d sum=%h carry=%b want 4 0002 1",
                     lat, sum, carry);
        end
        tick();
        sub = 1'b0;
    endtask
`endif

    task automatic test_one_nibble();
        int lat;
        x1 = 4'hF;
        y1 = 4'h1;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        x1 = 4'h0;
        y1 = 4'h0;
        checks++;
        if (busy1 !== 1'b1 || done1 !== 1'b0) begin
            errs++;
            $display("FAIL n1_busy: got busy=%b done=%b want 1 0", busy1, done1);
        end
        lat = 0;
        while (!done1 && lat < 20) begin
            tick();
            lat++;
        end
        checks++;
        if (lat !== 1 || sum1 !== 4'h0 || carry1 !== 1'b1) begin
            errs++;
            $display("FAIL n1_result: got lat=%0d sum=%h carry=%b want 1 0 1",
                     lat, sum1, carry1);
        end
        tick();
        checks++;
        if (done1 !== 1'b0 || carry1 !== 1'b1) begin
            errs++;
            $display("FAIL n1_hold: got done=%b carry=%b want 0 1", done1, carry1);
        end
    endtask

    initial begin
        errs = 0;
        checks = 0;
        start = 1'b0;
        x = '0;
        y = '0;
        sub = 1'b0;
        start1 = 1'b0;
        x1 = '0;
        y1 = '0;
        test_reset();
        test_basic();
        test_carry_ripple();
        test_back_to_back();
        test_reset_abort();
`ifdef ADDER_SEQ_SUB_EN
        test_subtract();
`endif
        test_one_nibble();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
